turing_tape_sched: RTL and testbench

//  Controller that shares one tape engine between NREQ requesters.

---
 rtl/turing_tape_sched_pkg.sv | 15 +
 rtl/turing_tape_sched_rr_arbiter.sv | 41 ++++
 rtl/turing_tape_sched.sv | 109 ++++++++++
 tb/tb_turing_tape_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/turing_tape_sched_pkg.sv
// Shared types and defaults for the tape-engine scheduler.
package turing_tape_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int DEF_TAPE_W    = 10;
  localparam int DEF_MAX_STEPS = 25;
  localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/turing_tape_sched_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping past NREQ-1.
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*NREQ-1:0] doubled;
  logic [2*NREQ-1:0] rotated;
  logic [IDX_W:0]    sum;
  logic              found;

  // Rotating a doubled copy puts the requester at ptr into bit 0.
  assign doubled = {req, req};
  assign rotated = doubled >> ptr;
  assign any     = |req;

  always_comb begin
    grant = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && rotated[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(j);
        if (sum >= (IDX_W+1)'(NREQ)) begin
          sum = sum - (IDX_W+1)'(NREQ);
        end
        idx   = sum[IDX_W-1:0];
        grant = NREQ'(1) << sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/turing_tape_sched.sv
// Shares one external tape engine between NREQ requesters: arbitrate, load,
// step to halt or budget, then hold the result for the owner.
module turing_tape_sched
  import turing_tape_sched_pkg::*;
#(
  parameter  int NREQ      = 2,
  parameter  int TAPE_W    = DEF_TAPE_W,
  parameter  int MAX_STEPS = DEF_MAX_STEPS,
  parameter  int CNT_W     = DEF_CNT_W,
  localparam int IDX_W     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*TAPE_W-1:0] req_tape,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [TAPE_W-1:0]      rsp_tape,
  output logic                   rsp_timeout,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic                   eng_load,
  output logic [TAPE_W-1:0]      eng_tape,
  output logic                   eng_step,
  input  logic                   eng_halt,
  input  logic [TAPE_W-1:0]      eng_tape_q,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner
);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;
  logic [TAPE_W-1:0] job_tape;
  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              budget_done;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // The step gate on the budget keeps the engine from taking a step past MAX_STEPS.
  assign budget_done = (count == CNT_W'(MAX_STEPS));
  assign eng_step    = (state == S_RUN) && !eng_halt && !budget_done;
  assign eng_load    = (state == S_LOAD);
  assign eng_tape    = job_tape;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      count       <= '0;
      owner       <= '0;
      job_tape    <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_tape    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        // The accept pulse occupies one IDLE cycle; the load follows it.
        S_IDLE: begin
          if (req_ready != '0) begin
            state <= S_LOAD;
          end else if (gnt_any) begin
            req_ready <= gnt;
            owner     <= gnt_idx;
            job_tape  <= req_tape[gnt_idx*TAPE_W +: TAPE_W];
          end
        end
        S_LOAD: begin
          count <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (eng_halt) begin
            rsp_tape    <= eng_tape_q;
            rsp_timeout <= 1'b0;
            rsp_valid   <= NREQ'(1) << owner;
            state       <= S_RESP;
          end else if (budget_done) begin
            rsp_tape    <= eng_tape_q;
            rsp_timeout <= 1'b1;
            rsp_valid   <= NREQ'(1) << owner;
            state       <= S_RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            ptr       <= (owner == IDX_W'(NREQ-1)) ? '0 : owner + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turing_tape_sched.sv
// Directed bench for turing_tape_sched with a small behavioural tape engine.
module tb_turing_tape_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [19:0] req_tape;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [9:0]  rsp_tape;
  logic        rsp_timeout;
  logic [1:0]  rsp_ready;
  logic        eng_load;
  logic [9:0]  eng_tape;
  logic        eng_step;
  logic        eng_halt;
  logic [9:0]  eng_tape_q;
  logic        busy;
  logic [0:0]  owner;

  int errors = 0;
  int checks = 0;

  // Engine model: halts once n_halt steps are taken, then shows res_tape.
  int         n_halt   = 1000;
  logic [9:0] res_tape = '0;
  int         m_steps  = 0;
  logic [9:0] m_tape   = '0;
  int         step_cnt = 0;

  turing_tape_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_tape    (req_tape),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_tape    (rsp_tape),
    .rsp_timeout (rsp_timeout),
    .rsp_ready   (rsp_ready),
    .eng_load    (eng_load),
    .eng_tape    (eng_tape),
    .eng_step    (eng_step),
    .eng_halt    (eng_halt),
    .eng_tape_q  (eng_tape_q),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  assign eng_halt   = (m_steps >= n_halt);
  assign eng_tape_q = eng_halt ? res_tape : m_tape;

  always @(posedge clk) begin
    if (eng_load) begin
      m_steps  <= 0;
      m_tape   <= eng_tape;
      step_cnt <= 0;
    end else if (eng_step) begin
      m_steps  <= m_steps + 1;
      m_tape   <= m_tape + 10'd1;
      step_cnt <= step_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitAccept(input string tag, input logic [1:0] exp_ready);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req_ready == 2'b00 && k < 40);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
  endtask

  task automatic finishJob(input string tag, input int idx, input logic [9:0] load_t,
                           input logic [9:0] exp_tape, input logic exp_to, input int exp_steps);
    int k = 0;
    @(negedge clk);
    checkOutput({tag, "_eng_load"}, 32'(eng_load), 32'd1);
    checkOutput({tag, "_eng_tape"}, 32'(eng_tape), 32'(load_t));
    checkOutput({tag, "_owner"}, 32'(owner), 32'(idx));
    @(negedge clk);
    checkOutput({tag, "_first_step"}, 32'({eng_load, eng_step}), 32'b01);
    while (rsp_valid == 2'b00 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << idx));
    checkOutput({tag, "_rsp_tape"}, 32'(rsp_tape), 32'(exp_tape));
    checkOutput({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(exp_to));
    checkOutput({tag, "_steps"}, 32'(step_cnt), 32'(exp_steps));
    rsp_ready = 2'(1 << idx);
    @(negedge clk);
    rsp_ready = 2'b00;
    checkOutput({tag, "_released"}, 32'({rsp_valid, busy}), 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input int idx, input logic [9:0] load_t,
                               input int n, input logic [9:0] res, input logic [9:0] exp_tape,
                               input logic exp_to, input int exp_steps, input bit drop);
    n_halt   = n;
    res_tape = res;
    req_tape[idx*10 +: 10] = load_t;
    req_valid[idx] = 1'b1;
    waitAccept(tag, 2'(1 << idx));
    if (drop) req_valid[idx] = 1'b0;
    finishJob(tag, idx, load_t, exp_tape, exp_to, exp_steps);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int s;
    rst       = 1'b1;
    req_valid = '0;
    req_tape  = '0;
    rsp_ready = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", 32'({req_ready, rsp_valid, rsp_timeout, eng_load, eng_step, busy, owner}), 32'd0);
    checkOutput("reset_tapes", 32'({rsp_tape, eng_tape}), 32'd0);
    rst = 1'b0;

    // Fairness: both requesters stay valid, service alternates from pointer 0.
    req_valid = 2'b11;
    applyStimulus("fair0", 0, 10'h001, 1, 10'h011, 10'h011, 1'b0, 1, 1'b0);
    applyStimulus("fair1", 1, 10'h002, 2, 10'h022, 10'h022, 1'b0, 2, 1'b0);
    applyStimulus("fair2", 0, 10'h003, 3, 10'h033, 10'h033, 1'b0, 3, 1'b0);
    applyStimulus("fair3", 1, 10'h004, 4, 10'h044, 10'h044, 1'b0, 4, 1'b0);
    req_valid = 2'b00;

    applyStimulus("single", 0, 10'h0F6, 5, 10'h07E, 10'h07E, 1'b0, 5, 1'b1);
    applyStimulus("timeout", 0, 10'h100, 1000, 10'h3FF, 10'h119, 1'b1, 25, 1'b1);
    applyStimulus("coincide", 1, 10'h2A5, 25, 10'h155, 10'h155, 1'b0, 25, 1'b1);

    // Reset in the middle of a run abandons the job.
    n_halt = 1000;
    req_tape[9:0] = 10'h3C3;
    req_valid[0] = 1'b1;
    waitAccept("midrst", 2'b01);
    req_valid[0] = 1'b0;
    k = 0;
    while (step_cnt != 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("midrst_reach_step3", 32'(step_cnt), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ctrl", 32'({req_ready, rsp_valid, rsp_timeout, eng_load, eng_step, busy, owner}), 32'd0);
    checkOutput("midrst_tapes", 32'({rsp_tape, eng_tape}), 32'd0);
    s = step_cnt;
    repeat (5) @(negedge clk);
    checkOutput("midrst_no_steps", 32'(step_cnt), 32'(s));
    checkOutput("midrst_no_rsp", 32'({rsp_valid, busy}), 32'd0);
    applyStimulus("postrst", 1, 10'h111, 3, 10'h222, 10'h222, 1'b0, 3, 1'b1);

    // Backpressure with a waiting requester and a stray rsp_ready bit.
    n_halt   = 2;
    res_tape = 10'h0AA;
    req_tape[9:0] = 10'h055;
    req_valid[0] = 1'b1;
    waitAccept("bp", 2'b01);
    req_valid[0] = 1'b0;
    k = 0;
    while (rsp_valid == 2'b00 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'b01);
    req_tape[19:10] = 10'h1F0;
    req_valid[1] = 1'b1;
    rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'b01);
      checkOutput("bp_hold_tape", 32'(rsp_tape), 32'h0AA);
      checkOutput("bp_hold_ready", 32'({req_ready, busy}), 32'b001);
    end
    n_halt   = 4;
    res_tape = 10'h3E8;
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    checkOutput("bp_release", 32'({rsp_valid, req_ready}), 32'd0);
    @(negedge clk);
    checkOutput("bp_next_accept", 32'(req_ready), 32'b10);
    req_valid[1] = 1'b0;
    finishJob("bp_next", 1, 10'h1F0, 10'h3E8, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
